// File: rtl/wb_pipe_pkg.sv
// Shared types for the MEM->WB boundary: payload layout and writeback data select.
package wb_pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RA_W   = 5;

  typedef struct packed {
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] dm_q;
    logic              rf_d_sel;
    logic              rf_we;
    logic [RA_W-1:0]   rd;
  } wb_payload_t;

  localparam int unsigned PAYLOAD_W = $bits(wb_payload_t);

  // Writeback data mux: load data when rf_d_sel is set, otherwise the ALU result.
  function automatic logic [DATA_W-1:0] wb_sel(input wb_payload_t p);
    return p.rf_d_sel ? p.dm_q : p.alu_res;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-entry skid register: main entry drives the output, skid entry absorbs
// one payload when the consumer stalls so that in_ready never depends on out_ready.
module pipe_skid_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_v;
  logic         skid_v;
  logic [W-1:0] main_d;
  logic [W-1:0] skid_d;
  logic         main_free;
  logic         accept;

  assign main_free = !main_v || out_ready;
  assign accept    = in_valid && !skid_v;

  // Skid refills main before any new input is taken, which keeps ordering intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (main_free) begin
      if (skid_v) begin
        main_d <= skid_d;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        if (accept) main_d <= in_data;
        main_v <= accept;
      end
    end else if (accept) begin
      skid_d <= in_data;
      skid_v <= 1'b1;
    end
  end

  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline boundary with handshake, skid buffer, flush, data select and forwarding.
// Optional WB_PIPE_STATS_EN adds saturating stall/bubble counters.
module wb_pipe_stage
  import wb_pipe_pkg::wb_payload_t;
  import wb_pipe_pkg::wb_sel;
  import wb_pipe_pkg::PAYLOAD_W;
#(
  parameter int unsigned DATA_W = wb_pipe_pkg::DATA_W,
  parameter int unsigned RA_W   = wb_pipe_pkg::RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FLUSH,
  input  logic              MEM_VALID,
  output logic              MEM_READY,
  input  logic [DATA_W-1:0] MEM_ALU_RES,
  input  logic [DATA_W-1:0] MEM_DM_Q,
  input  logic              MEM_RF_D_SEL,
  input  logic              MEM_RF_WE,
  input  logic [RA_W-1:0]   MEM_RD,
  output logic              WB_VALID,
  input  logic              WB_READY,
  output logic [DATA_W-1:0] WB_ALU_RES,
  output logic [DATA_W-1:0] WB_DM_Q,
  output logic              WB_RF_D_SEL,
  output logic              WB_RF_WE,
  output logic [RA_W-1:0]   WB_RD,
  output logic [DATA_W-1:0] WB_RF_D,
  output logic              FWD_VALID,
  output logic [RA_W-1:0]   FWD_RD,
  output logic [DATA_W-1:0] FWD_D
`ifdef WB_PIPE_STATS_EN
  ,
  output logic [15:0]       STALL_CNT,
  output logic [15:0]       BUBBLE_CNT
`endif
);

  wb_payload_t in_pl;
  wb_payload_t out_pl;

  always_comb begin
    in_pl          = '0;
    in_pl.alu_res  = MEM_ALU_RES;
    in_pl.dm_q     = MEM_DM_Q;
    in_pl.rf_d_sel = MEM_RF_D_SEL;
    in_pl.rf_we    = MEM_RF_WE;
    in_pl.rd       = MEM_RD;
  end

  pipe_skid_reg #(
    .W (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (FLUSH),
    .in_valid  (MEM_VALID),
    .in_ready  (MEM_READY),
    .in_data   (in_pl),
    .out_valid (WB_VALID),
    .out_ready (WB_READY),
    .out_data  (out_pl)
  );

  assign WB_ALU_RES  = out_pl.alu_res;
  assign WB_DM_Q     = out_pl.dm_q;
  assign WB_RF_D_SEL = out_pl.rf_d_sel;
  assign WB_RD       = out_pl.rd;
  assign WB_RF_D     = wb_sel(out_pl);

  // Stale payload after a flush is masked by the valid bit.
  assign WB_RF_WE  = WB_VALID && out_pl.rf_we;
  assign FWD_VALID = WB_RF_WE && (out_pl.rd != '0);
  assign FWD_RD    = out_pl.rd;
  assign FWD_D     = WB_RF_D;

`ifdef WB_PIPE_STATS_EN
  logic stall;
  logic bubble;

  assign stall  = WB_VALID && !WB_READY;
  assign bubble = !WB_VALID;

  // Saturating counters; FLUSH deliberately leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      STALL_CNT  <= 16'd0;
      BUBBLE_CNT <= 16'd0;
    end else begin
      if (stall && (STALL_CNT != 16'hFFFF))   STALL_CNT  <= STALL_CNT + 16'd1;
      if (bubble && (BUBBLE_CNT != 16'hFFFF)) BUBBLE_CNT <= BUBBLE_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed self-checking bench for wb_pipe_stage; stats checks compile in with WB_PIPE_STATS_EN.
module tb_wb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_alu_res;
  logic [31:0] mem_dm_q;
  logic        mem_rf_d_sel;
  logic        mem_rf_we;
  logic [4:0]  mem_rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_alu_res;
  logic [31:0] wb_dm_q;
  logic        wb_rf_d_sel;
  logic        wb_rf_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rf_d;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_d;
`ifdef WB_PIPE_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_pipe_stage dut (
    .clk          (clk),
    .rst          (rst),
    .FLUSH        (flush),
    .MEM_VALID    (mem_valid),
    .MEM_READY    (mem_ready),
    .MEM_ALU_RES  (mem_alu_res),
    .MEM_DM_Q     (mem_dm_q),
    .MEM_RF_D_SEL (mem_rf_d_sel),
    .MEM_RF_WE    (mem_rf_we),
    .MEM_RD       (mem_rd),
    .WB_VALID     (wb_valid),
    .WB_READY     (wb_ready),
    .WB_ALU_RES   (wb_alu_res),
    .WB_DM_Q      (wb_dm_q),
    .WB_RF_D_SEL  (wb_rf_d_sel),
    .WB_RF_WE     (wb_rf_we),
    .WB_RD        (wb_rd),
    .WB_RF_D      (wb_rf_d),
    .FWD_VALID    (fwd_valid),
    .FWD_RD       (fwd_rd),
    .FWD_D        (fwd_d)
`ifdef WB_PIPE_STATS_EN
    ,
    .STALL_CNT    (stall_cnt),
    .BUBBLE_CNT   (bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] dq,
                       input logic sel, input logic we, input logic [4:0] rd);
    mem_valid    = v;
    mem_alu_res  = alu;
    mem_dm_q     = dq;
    mem_rf_d_sel = sel;
    mem_rf_we    = we;
    mem_rd       = rd;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);
    chk("rst_alu", 64'(wb_alu_res), 64'd0);
    chk("rst_rf_we", 64'(wb_rf_we), 64'd0);

    // Streaming, one payload per cycle
    wb_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 32'h0, 1'b0, 1'b1, 5'(i));
      tick();
      chk("stream_valid", 64'(wb_valid), 64'd1);
      chk("stream_alu", 64'(wb_alu_res), 64'(i));
      chk("stream_ready", 64'(mem_ready), 64'd1);
      chk("stream_fwd_d", 64'(fwd_d), 64'(i));
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    tick();
    chk("stream_drain", 64'(wb_valid), 64'd0);

    // Stall: A in main, B into skid, extra input ignored while full
    wb_ready = 1'b0;
    drive(1'b1, 32'd10, 32'd0, 1'b0, 1'b1, 5'd1);
    tick();
    chk("stall_a_main", 64'(wb_alu_res), 64'd10);
    drive(1'b1, 32'd11, 32'd0, 1'b0, 1'b1, 5'd2);
    tick();
    chk("stall_a_held", 64'(wb_alu_res), 64'd10);
    chk("stall_ready_low", 64'(mem_ready), 64'd0);
    drive(1'b1, 32'd12, 32'd0, 1'b0, 1'b1, 5'd3);
    tick();
    chk("stall_still_a", 64'(wb_alu_res), 64'd10);
    chk("stall_still_full", 64'(mem_ready), 64'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    wb_ready = 1'b1;
    tick();
    chk("release_b_valid", 64'(wb_valid), 64'd1);
    chk("release_b_alu", 64'(wb_alu_res), 64'd11);
    chk("release_ready", 64'(mem_ready), 64'd1);
    tick();
    chk("release_empty", 64'(wb_valid), 64'd0);

    // Flush with both entries full; flush-cycle input is lost
    wb_ready = 1'b0;
    drive(1'b1, 32'd20, 32'd0, 1'b0, 1'b1, 5'd5);
    tick();
    drive(1'b1, 32'd21, 32'd0, 1'b0, 1'b1, 5'd6);
    tick();
    chk("flush_pre_full", 64'(mem_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'd22, 32'd0, 1'b0, 1'b1, 5'd7);
    tick();
    chk("flush_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_mem_ready", 64'(mem_ready), 64'd1);
    chk("flush_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("flush_rf_we", 64'(wb_rf_we), 64'd0);
    flush = 1'b0;
    wb_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    tick();
    chk("flush_nothing_left", 64'(wb_valid), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'd23, 32'd0, 1'b0, 1'b1, 5'd8);
    tick();
    chk("flush_beats_accept", 64'(wb_valid), 64'd0);
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    tick();
    chk("flush_input_gone", 64'(wb_valid), 64'd0);

    // Data select and forwarding
    drive(1'b1, 32'd5, 32'hDEADBEEF, 1'b1, 1'b1, 5'd3);
    tick();
    chk("sel_rf_d", 64'(wb_rf_d), 64'hDEADBEEF);
    chk("sel_fwd_valid", 64'(fwd_valid), 64'd1);
    chk("sel_fwd_rd", 64'(fwd_rd), 64'd3);
    chk("sel_fwd_d", 64'(fwd_d), 64'hDEADBEEF);
    drive(1'b1, 32'd5, 32'hDEADBEEF, 1'b1, 1'b1, 5'd0);
    tick();
    chk("rd0_rf_we", 64'(wb_rf_we), 64'd1);
    chk("rd0_fwd_valid", 64'(fwd_valid), 64'd0);
    drive(1'b1, 32'd9, 32'h12345678, 1'b0, 1'b0, 5'd7);
    tick();
    chk("alu_rf_d", 64'(wb_rf_d), 64'd9);
    chk("we0_rf_we", 64'(wb_rf_we), 64'd0);
    chk("we0_fwd_valid", 64'(fwd_valid), 64'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    tick();

    // Reset mid-stall
    wb_ready = 1'b0;
    drive(1'b1, 32'd30, 32'h55, 1'b1, 1'b1, 5'd4);
    tick();
    drive(1'b1, 32'd31, 32'h66, 1'b1, 1'b1, 5'd9);
    tick();
    chk("rst_pre_full", 64'(mem_ready), 64'd0);
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    tick();
    chk("rst2_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst2_mem_ready", 64'(mem_ready), 64'd1);
    chk("rst2_alu", 64'(wb_alu_res), 64'd0);
    chk("rst2_dm_q", 64'(wb_dm_q), 64'd0);
    chk("rst2_sel", 64'(wb_rf_d_sel), 64'd0);
    chk("rst2_rd", 64'(wb_rd), 64'd0);
    chk("rst2_rf_we", 64'(wb_rf_we), 64'd0);
`ifdef WB_PIPE_STATS_EN
    chk("rst2_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst2_bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
    rst = 1'b0;
    wb_ready = 1'b1;
    tick();
    chk("rst2_skid_dropped", 64'(wb_valid), 64'd0);
`ifdef WB_PIPE_STATS_EN
    chk("bubble_one", 64'(bubble_cnt), 64'd1);

    // Stall counter saturation
    wb_ready = 1'b0;
    drive(1'b1, 32'd40, 32'd0, 1'b0, 1'b1, 5'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    for (int c = 0; c < 70000; c++) tick();
    chk("stall_sat_valid", 64'(wb_valid), 64'd1);
    chk("stall_saturated", 64'(stall_cnt), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
